// File: rtl/r88_regfile_gen.sv
// Rocket88 register block, parametrised: GP bytes, 16-bit pairs with PC/SP stepping,
// registered read port and registered ALU-operand / address outputs.
module r88_regfile_gen #(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       NUM_GP   = 3,
  parameter int unsigned       NUM_PAIR = 4,
  parameter int unsigned       PC_IDX   = 2,
  parameter int unsigned       SP_IDX   = 3,
  parameter logic [2*DATA_W-1:0] PC_RST = 16'hFFFE,
  parameter logic [2*DATA_W-1:0] SP_RST = 16'hFFF9,
  parameter int unsigned       SEL_W    = 4
) (
  input  logic                sysClock,
  input  logic                sysReset,
  input  logic                wrEn,
  input  logic [SEL_W-1:0]    wrSel,
  input  logic [DATA_W-1:0]   wrData,
  input  logic                wr16,
  input  logic [DATA_W-1:0]   wrHigh,
  input  logic                rdEn,
  input  logic [SEL_W-1:0]    rdSel,
  output logic [DATA_W-1:0]   rdData,
  input  logic [1:0]          rightSel,
  output logic [DATA_W-1:0]   regRight,
  input  logic [2:0]          leftSel,
  input  logic                left16,
  output logic [2*DATA_W-1:0] regLeft,
  input  logic [2:0]          addrSel,
  output logic [2*DATA_W-1:0] regAddr,
  input  logic                incPC,
  input  logic [1:0]          spOp,
  input  logic [5:0]          flagsIn
);

  localparam int unsigned PAIR_W = 2 * DATA_W;
  localparam int unsigned STATUS_SEL = NUM_GP + 2 * NUM_PAIR;

  if (DATA_W == 0 || NUM_GP < 3 || NUM_GP > 8 || NUM_PAIR < 2 || NUM_PAIR > 6 ||
      PC_IDX >= NUM_PAIR || SP_IDX >= NUM_PAIR || PC_IDX == SP_IDX ||
      STATUS_SEL >= (1 << SEL_W)) begin : g_bad_cfg
    $error("r88_regfile_gen: illegal parameter configuration");
  end

  logic [DATA_W-1:0] gp_q   [NUM_GP];
  logic [DATA_W-1:0] gp_d   [NUM_GP];
  logic [PAIR_W-1:0] pair_q [NUM_PAIR];
  logic [PAIR_W-1:0] pair_d [NUM_PAIR];

  logic [DATA_W-1:0] rd_q, rd_d, right_q, right_d;
  logic [PAIR_W-1:0] left_q, left_d, addr_q, addr_d;

  int unsigned ws, rs, rts, ls, as;
  assign ws  = 32'(wrSel);
  assign rs  = 32'(rdSel);
  assign rts = 32'(rightSel);
  assign ls  = 32'(leftSel);
  assign as  = 32'(addrSel);

  // Stepping is applied first; a write to any byte of a pair rebuilds it from
  // the pre-edge value, so the write wins and the step is dropped.
  always_comb begin
    gp_d   = gp_q;
    pair_d = pair_q;
    if (incPC) pair_d[PC_IDX] = pair_q[PC_IDX] + PAIR_W'(1);
    case (spOp)
      2'b01:   pair_d[SP_IDX] = pair_q[SP_IDX] - PAIR_W'(1);
      2'b10:   pair_d[SP_IDX] = pair_q[SP_IDX] + PAIR_W'(1);
      default: ;
    endcase
    if (wrEn) begin
      for (int unsigned i = 0; i < NUM_GP; i++)
        if (ws == i) gp_d[i] = wrData;
      for (int unsigned k = 0; k < NUM_PAIR; k++) begin
        if (ws == NUM_GP + 2*k)
          pair_d[k] = {(wr16 ? wrHigh : pair_q[k][PAIR_W-1:DATA_W]), wrData};
        else if (ws == NUM_GP + 2*k + 1)
          pair_d[k] = {wrData, pair_q[k][DATA_W-1:0]};
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int unsigned i = 0; i < NUM_GP; i++)
      if (rs == i) rd_d = gp_q[i];
    for (int unsigned k = 0; k < NUM_PAIR; k++) begin
      if (rs == NUM_GP + 2*k)     rd_d = pair_q[k][DATA_W-1:0];
      if (rs == NUM_GP + 2*k + 1) rd_d = pair_q[k][PAIR_W-1:DATA_W];
    end
    if (rs == STATUS_SEL) rd_d = DATA_W'({flagsIn, 2'b00});

    right_d = '0;
    for (int unsigned i = 0; i < NUM_GP; i++)
      if (rts == i + 1) right_d = gp_q[i];

    left_d = '0;
    if (left16) begin
      for (int unsigned k = 0; k < NUM_PAIR; k++)
        if (ls == k) left_d = pair_q[k];
    end else begin
      for (int unsigned i = 0; i < NUM_GP; i++)
        if (ls == i + 1) left_d = PAIR_W'(gp_q[i]);
    end

    addr_d = {gp_q[1], gp_q[2]};
    if (as != 0) begin
      addr_d = '0;
      for (int unsigned k = 0; k < NUM_PAIR; k++)
        if (as == k + 1) addr_d = pair_q[k];
    end
  end

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      for (int unsigned i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
      for (int unsigned k = 0; k < NUM_PAIR; k++)
        pair_q[k] <= (k == PC_IDX) ? PC_RST : ((k == SP_IDX) ? SP_RST : '0);
      rd_q    <= '0;
      right_q <= '0;
      left_q  <= '0;
      addr_q  <= '0;
    end else begin
      gp_q    <= gp_d;
      pair_q  <= pair_d;
      if (rdEn) rd_q <= rd_d;
      right_q <= right_d;
      left_q  <= left_d;
      addr_q  <= addr_d;
    end
  end

  assign rdData   = rd_q;
  assign regRight = right_q;
  assign regLeft  = left_q;
  assign regAddr  = addr_q;

endmodule

// File: tb/tb_r88_regfile_gen.sv
// Scoreboard bench for r88_regfile_gen: driver queues hand-computed expectations,
// a negedge monitor pops and checks them when they fall due.
module tb_r88_regfile_gen;

  logic        sysClock, sysReset, wrEn, wr16, rdEn, left16, incPC;
  logic [3:0]  wrSel, rdSel;
  logic [7:0]  wrData, wrHigh, rdData, regRight;
  logic [1:0]  rightSel, spOp;
  logic [2:0]  leftSel, addrSel;
  logic [15:0] regLeft, regAddr;
  logic [5:0]  flagsIn;

  r88_regfile_gen #(.DATA_W(8), .NUM_GP(3), .NUM_PAIR(4), .PC_IDX(2), .SP_IDX(3),
                    .PC_RST(16'hFFFE), .SP_RST(16'hFFF9), .SEL_W(4)) dut (
    .sysClock(sysClock), .sysReset(sysReset), .wrEn(wrEn), .wrSel(wrSel),
    .wrData(wrData), .wr16(wr16), .wrHigh(wrHigh), .rdEn(rdEn), .rdSel(rdSel),
    .rdData(rdData), .rightSel(rightSel), .regRight(regRight), .leftSel(leftSel),
    .left16(left16), .regLeft(regLeft), .addrSel(addrSel), .regAddr(regAddr),
    .incPC(incPC), .spOp(spOp), .flagsIn(flagsIn)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  int unsigned cyc = 0;
  always @(posedge sysClock) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    int unsigned kind;   // 0 rdData, 1 regRight, 2 regLeft, 3 regAddr
    logic [15:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] actual(input int unsigned kind);
    case (kind)
      0:       return {8'h00, rdData};
      1:       return {8'h00, regRight};
      2:       return regLeft;
      default: return regAddr;
    endcase
  endfunction

  always @(negedge sysClock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      n_cmp++;
      if (cur.due != cyc) begin
        n_bad++;
        $display("FAIL %s: expectation stale at cycle %0d (due %0d)", cur.name, cyc, cur.due);
      end else if (actual(cur.kind) !== cur.val) begin
        n_bad++;
        $display("FAIL %s: got %h, expected %h", cur.name, actual(cur.kind), cur.val);
      end
    end
  end

  task automatic idle();
    sysReset = 1'b0; wrEn = 1'b0; wrSel = '0; wrData = '0; wr16 = 1'b0; wrHigh = '0;
    rdEn = 1'b0; rdSel = '0; rightSel = '0; leftSel = '0; left16 = 1'b0;
    addrSel = '0; incPC = 1'b0; spOp = '0; flagsIn = '0;
  endtask

  task automatic next();
    @(negedge sysClock);
    idle();
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] d, input logic w16, input logic [7:0] hi);
    wrEn = 1'b1; wrSel = s; wrData = d; wr16 = w16; wrHigh = hi;
  endtask

  // Expected value of an output right after the coming rising edge.
  task automatic chk(input int unsigned kind, input logic [15:0] v, input string nm);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    idle(); sysReset = 1'b1;
    chk(0, 16'h0000, "rst_rd"); chk(1, 16'h0000, "rst_right");
    chk(2, 16'h0000, "rst_left"); chk(3, 16'h0000, "rst_addr");
    next(); wr(4'd0, 8'hAA, 1'b0, 8'h00);
    next(); wr(4'd1, 8'h12, 1'b0, 8'h00);
    next(); wr(4'd2, 8'h34, 1'b0, 8'h00); incPC = 1'b1;
    // reset mid-operation with a write, step and reads all pending
    next(); sysReset = 1'b1; wr(4'd0, 8'h55, 1'b0, 8'h00); incPC = 1'b1;
    rdEn = 1'b1; rdSel = 4'd1; rightSel = 2'd1; leftSel = 3'd2; left16 = 1'b1;
    chk(0, 16'h0000, "rst2_rd"); chk(1, 16'h0000, "rst2_right");
    chk(2, 16'h0000, "rst2_left"); chk(3, 16'h0000, "rst2_addr");
    next(); rdEn = 1'b1; rdSel = 4'd1; rightSel = 2'd1; addrSel = 3'd3; leftSel = 3'd3; left16 = 1'b1;
    chk(0, 16'h0000, "rst_B"); chk(1, 16'h0000, "rst_A_write_dropped");
    chk(3, 16'hFFFE, "rst_PC"); chk(2, 16'hFFF9, "rst_SP");
    next(); wr(4'd3, 8'h34, 1'b1, 8'h12);
    next(); leftSel = 3'd0; left16 = 1'b1; wr(4'd7, 8'hFF, 1'b0, 8'h00);
    chk(2, 16'h1234, "dd_wr16");
    next(); incPC = 1'b1; addrSel = 3'd3; chk(3, 16'hFFFF, "pc_ffff");
    next(); addrSel = 3'd3; wr(4'd7, 8'h10, 1'b1, 8'h00); chk(3, 16'h0000, "pc_wrap");
    next(); addrSel = 3'd3; incPC = 1'b1; wr(4'd7, 8'h55, 1'b0, 8'h00); chk(3, 16'h0010, "pc_0010");
    next(); addrSel = 3'd3; wr(4'd9, 8'h00, 1'b1, 8'h00); chk(3, 16'h0055, "pc_wr_wins");
    next(); addrSel = 3'd4; spOp = 2'b01; chk(3, 16'h0000, "sp_0000");
    next(); addrSel = 3'd4; spOp = 2'b10; chk(3, 16'hFFFF, "sp_dec_wrap");
    next(); addrSel = 3'd4; spOp = 2'b11; chk(3, 16'h0000, "sp_inc_wrap");
    next(); addrSel = 3'd4; spOp = 2'b01; wr(4'd10, 8'h12, 1'b0, 8'h00); chk(3, 16'h0000, "sp_nop");
    next(); addrSel = 3'd4; wr(4'd0, 8'hAA, 1'b0, 8'h00); chk(3, 16'h1200, "sp_wr_wins");
    next(); rdEn = 1'b1; rdSel = 4'd0; wr(4'd0, 8'h5A, 1'b0, 8'h00); chk(0, 16'h00AA, "rd_pre_write");
    next(); rdEn = 1'b1; rdSel = 4'd0; wr(4'd1, 8'h12, 1'b0, 8'h00); chk(0, 16'h005A, "rd_reread");
    next(); rdSel = 4'd2; wr(4'd2, 8'h34, 1'b0, 8'h00); chk(0, 16'h005A, "rd_hold");
    next(); addrSel = 3'd0; rdEn = 1'b1; rdSel = 4'd11; flagsIn = 6'b101010; rightSel = 2'd2;
    chk(3, 16'h1234, "addr_bc"); chk(0, 16'h00A8, "rd_status"); chk(1, 16'h0012, "right_B");
    next(); rdEn = 1'b1; rdSel = 4'd15; rightSel = 2'd3; leftSel = 3'd2; left16 = 1'b0;
    chk(0, 16'h0000, "rd_invalid"); chk(1, 16'h0034, "right_C"); chk(2, 16'h0012, "left8_B");
    next(); rdEn = 1'b1; rdSel = 4'd4; leftSel = 3'd4; addrSel = 3'd5;
    chk(0, 16'h0012, "rd_dd_hi"); chk(2, 16'h0000, "left8_oor");
    chk(3, 16'h0000, "addr_oor"); chk(1, 16'h0000, "right_zero");
    next(); rdEn = 1'b1; rdSel = 4'd3; leftSel = 3'd5; left16 = 1'b1; addrSel = 3'd1; rightSel = 2'd1;
    chk(0, 16'h0034, "rd_dd_lo"); chk(2, 16'h0000, "left16_oor");
    chk(3, 16'h1234, "addr_dd"); chk(1, 16'h005A, "right_A");
    next();
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge sysClock);
    #1;
    if (sb.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expectations still queued, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
